// File: rtl/issue_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// issue_arbiter_pkg
// Shared definitions for the issue arbiter slice:
//   - source tags carried on out_src (alu / mem / term)
//   - FSM state encoding for the arbiter (RUN / FLUSH)
//   - mod3_add helper used for round-robin pointer arithmetic
// The renamed-op width `RENAMED_OP_SZ normally comes from the global defines.
// A fallback value is provided here only so the slice elaborates standalone.
// -----------------------------------------------------------------------------
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

package issue_arbiter_pkg;

  localparam logic [1:0] ISSUE_SRC_ALU  = 2'd0;
  localparam logic [1:0] ISSUE_SRC_MEM  = 2'd1;
  localparam logic [1:0] ISSUE_SRC_TERM = 2'd2;

  typedef enum logic {
    ARB_RUN   = 1'b0,
    ARB_FLUSH = 1'b1
  } arb_state_e;

  // (a + b) mod 3 for a in 0..3, b in 0..2. A single conditional subtract is
  // enough because the sum never exceeds 5; an illegal a=3 folds onto 0.
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

endpackage

// File: rtl/issue_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational 3-way round-robin picker.
//   req     [2:0]  request vector, bit i = source i has a candidate
//   ptr     [1:0]  highest-priority source this cycle (0..2)
//   gnt     [2:0]  one-hot grant (all zero when no request)
//   gnt_idx [1:0]  index of the granted source (0 when no request)
// Search order is ptr, ptr+1, ptr+2 (all mod 3); first requester wins.
// -----------------------------------------------------------------------------
module rr_pick3
  import issue_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] gnt_idx
);

  // cand[k] is the source examined at search position k.
  logic [1:0] cand [3];
  logic [2:0] hit;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
      assign cand[gi] = mod3_add(ptr, 2'(gi));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk positions from last to first so the earliest hit overwrites later ones.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 2; k >= 0; k--) begin
      if (hit[k]) begin
        gnt     = 3'b001 << cand[k];
        gnt_idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// -----------------------------------------------------------------------------
// issue_arbiter
// Shares the single execute dispatch port between the alu, mem and term issue
// buffers. Each cycle at most one ready op is picked round-robin and loaded
// into a one-entry output register together with its source tag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   {alu,mem,term}_op        candidate ops (OP_W bits)
//   {alu,mem,term}_op_valid  candidate present
//   {alu,mem,term}_op_ready  grant; op consumed on valid & ready
//   flush                    single-cycle pulse: drop held op, restart arb
//   out_op / out_src         registered granted op and its source tag
//   out_valid / out_ready    output handshake to register-read/execute
//   perf_*_cnt               16-bit saturating counters, ISSUE_ARB_PERF_EN only
//
// Optional feature macro: ISSUE_ARB_PERF_EN (performance counters).
// -----------------------------------------------------------------------------
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

module issue_arbiter
  import issue_arbiter_pkg::*;
#(
  parameter int OP_W = `RENAMED_OP_SZ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] alu_op,
  input  logic [OP_W-1:0] mem_op,
  input  logic [OP_W-1:0] term_op,
  input  logic            alu_op_valid,
  input  logic            mem_op_valid,
  input  logic            term_op_valid,
  output logic            alu_op_ready,
  output logic            mem_op_ready,
  output logic            term_op_ready,
  input  logic            flush,
  output logic [OP_W-1:0] out_op,
  output logic [1:0]      out_src,
  output logic            out_valid,
  input  logic            out_ready
`ifdef ISSUE_ARB_PERF_EN
  ,
  output logic [15:0]     perf_alu_cnt,
  output logic [15:0]     perf_mem_cnt,
  output logic [15:0]     perf_term_cnt,
  output logic [15:0]     perf_stall_cnt
`endif
);

  arb_state_e      state_reg, state_next;
  logic [1:0]      rr_ptr_reg;
  logic            out_valid_reg;
  logic [OP_W-1:0] out_op_reg;
  logic [1:0]      out_src_reg;

  logic [OP_W-1:0] op_vec [3];
  logic [2:0]      req;
  logic [2:0]      gnt;
  logic [2:0]      rdy_vec;
  logic [1:0]      gnt_idx;
  logic            load;
  logic            grant;

  assign op_vec[ISSUE_SRC_ALU]  = alu_op;
  assign op_vec[ISSUE_SRC_MEM]  = mem_op;
  assign op_vec[ISSUE_SRC_TERM] = term_op;

  assign req = {term_op_valid, mem_op_valid, alu_op_valid};

  rr_pick3 u_pick (
    .req     (req),
    .ptr     (rr_ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The output slot may be refilled when empty or being drained this cycle.
  // rst is folded in so no ready escapes while reset is held.
  assign load  = ~rst & (state_reg == ARB_RUN) & ~flush & (~out_valid_reg | out_ready);
  assign grant = load & (|req);

  // gnt is already zero for sources whose valid is low.
  assign rdy_vec       = gnt & {3{load}};
  assign alu_op_ready  = rdy_vec[ISSUE_SRC_ALU];
  assign mem_op_ready  = rdy_vec[ISSUE_SRC_MEM];
  assign term_op_ready = rdy_vec[ISSUE_SRC_TERM];

  assign out_op    = out_op_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

  // FLUSH lasts one cycle unless another flush pulse arrives.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_RUN:   if (flush) state_next = ARB_FLUSH;
      ARB_FLUSH: state_next = flush ? ARB_FLUSH : ARB_RUN;
      default:   state_next = ARB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB_RUN;
      rr_ptr_reg    <= 2'd0;
      out_valid_reg <= 1'b0;
      out_op_reg    <= '0;
      out_src_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        // Any held op is dropped, even if execute accepts it this cycle.
        out_valid_reg <= 1'b0;
        rr_ptr_reg    <= 2'd0;
      end else if (load) begin
        if (grant) begin
          out_op_reg    <= op_vec[gnt_idx];
          out_src_reg   <= gnt_idx;
          out_valid_reg <= 1'b1;
          rr_ptr_reg    <= mod3_add(gnt_idx, 2'd1);
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

`ifdef ISSUE_ARB_PERF_EN
  logic [15:0] perf_src_cnt_reg [3];
  logic [15:0] perf_stall_cnt_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf_src
      always_ff @(posedge clk) begin
        if (rst) begin
          perf_src_cnt_reg[gi] <= 16'd0;
        end else if (rdy_vec[gi] && (perf_src_cnt_reg[gi] != 16'hFFFF)) begin
          perf_src_cnt_reg[gi] <= perf_src_cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  // A stall is any cycle with a pending candidate that is not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_reg <= 16'd0;
    end else if ((|req) && !grant && (perf_stall_cnt_reg != 16'hFFFF)) begin
      perf_stall_cnt_reg <= perf_stall_cnt_reg + 16'd1;
    end
  end

  assign perf_alu_cnt   = perf_src_cnt_reg[ISSUE_SRC_ALU];
  assign perf_mem_cnt   = perf_src_cnt_reg[ISSUE_SRC_MEM];
  assign perf_term_cnt  = perf_src_cnt_reg[ISSUE_SRC_TERM];
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_issue_arbiter.sv
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

module tb_issue_arbiter;

  localparam int OP_W = `RENAMED_OP_SZ;

  logic            clk = 1'b0;
  logic            rst;
  logic [OP_W-1:0] alu_op, mem_op, term_op;
  logic            alu_op_valid, mem_op_valid, term_op_valid;
  logic            alu_op_ready, mem_op_ready, term_op_ready;
  logic            flush;
  logic [OP_W-1:0] out_op;
  logic [1:0]      out_src;
  logic            out_valid;
  logic            out_ready;
`ifdef ISSUE_ARB_PERF_EN
  logic [15:0]     perf_alu_cnt, perf_mem_cnt, perf_term_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  issue_arbiter #(.OP_W(OP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_op        (alu_op),
    .mem_op        (mem_op),
    .term_op       (term_op),
    .alu_op_valid  (alu_op_valid),
    .mem_op_valid  (mem_op_valid),
    .term_op_valid (term_op_valid),
    .alu_op_ready  (alu_op_ready),
    .mem_op_ready  (mem_op_ready),
    .term_op_ready (term_op_ready),
    .flush         (flush),
    .out_op        (out_op),
    .out_src       (out_src),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
`ifdef ISSUE_ARB_PERF_EN
    ,
    .perf_alu_cnt  (perf_alu_cnt),
    .perf_mem_cnt  (perf_mem_cnt),
    .perf_term_cnt (perf_term_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Directed phase uses fixed ops per source so out_op is predictable.
  function automatic logic [OP_W-1:0] dir_op(input logic [1:0] s);
    case (s)
      2'd0:    return OP_W'('hAB);
      2'd1:    return OP_W'('h5C);
      default: return OP_W'('h7E);
    endcase
  endfunction

  // One clock of stimulus: readies checked mid-cycle, registers after the edge.
  task automatic cyc(input string nm, input bit r, input bit f, input bit rdy,
                     input bit [2:0] v, input bit [2:0] erdy, input bit eov,
                     input bit [1:0] esrc, input bit csrc);
    rst = r; flush = f; out_ready = rdy;
    {term_op_valid, mem_op_valid, alu_op_valid} = v;
    @(negedge clk);
    chk({nm, ".ready"}, 64'({term_op_ready, mem_op_ready, alu_op_ready}), 64'(erdy));
    @(posedge clk); #1;
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(eov));
    if (csrc) chk({nm, ".out_src"}, 64'(out_src), 64'(esrc));
    if (eov)  chk({nm, ".out_op"}, 64'(out_op), 64'(dir_op(esrc)));
    $display("txn %s: rdy=%b out_valid=%b out_src=%0d", nm,
             {term_op_ready, mem_op_ready, alu_op_ready}, out_valid, out_src);
  endtask

  typedef struct {
    bit       r;
    bit       f;
    bit       rdy;
    bit [2:0] v;     // {term, mem, alu}
    bit [2:0] erdy;  // {term, mem, alu}
    bit       eov;
    bit [1:0] esrc;
    bit       csrc;
  } vec_t;

  vec_t tbl [18];

  // ---------------- reference model (spec-level) ----------------
  bit              m_ov;
  logic [OP_W-1:0] m_op;
  int              m_src;
  int              m_ptr;
  bit              m_blk;   // a post-flush cycle in which nothing may be granted
  int              m_cnt [4];

  task automatic model_cycle(output logic [2:0] erdy);
    bit [2:0] v;
    bit       can;
    int       win;
    int       s;
    logic [OP_W-1:0] ops [3];
    v = {term_op_valid, mem_op_valid, alu_op_valid};
    ops[0] = alu_op; ops[1] = mem_op; ops[2] = term_op;
    erdy = '0;
    if (rst) begin
      m_ov = 0; m_op = '0; m_src = 0; m_ptr = 0; m_blk = 0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      return;
    end
    can = !m_blk && !flush && (!m_ov || out_ready);
    win = -1;
    for (int k = 0; k < 3; k++) begin
      s = (m_ptr + k) % 3;
      if (win < 0 && v[s]) win = s;
    end
    if (can && win >= 0) begin
      erdy[win] = 1'b1;
      if (m_cnt[win] < 65535) m_cnt[win]++;
    end else if (v != 0) begin
      if (m_cnt[3] < 65535) m_cnt[3]++;
    end
    if (flush) begin
      m_ov = 0; m_ptr = 0; m_blk = 1;
    end else begin
      m_blk = 0;
      if (can) begin
        if (win >= 0) begin
          m_ov = 1; m_op = ops[win]; m_src = win; m_ptr = (win + 1) % 3;
        end else begin
          m_ov = 0;
        end
      end
    end
  endtask

  initial begin
    logic [2:0] erdy;
    bit r, f, rdy;

    // rst, flush, rdy, v, erdy, eov, esrc, csrc
    tbl[0]  = '{1, 0, 1, 3'b111, 3'b000, 0, 0, 1};  // rotation
    tbl[1]  = '{0, 0, 1, 3'b111, 3'b001, 1, 0, 1};
    tbl[2]  = '{0, 0, 1, 3'b111, 3'b010, 1, 1, 1};
    tbl[3]  = '{0, 0, 1, 3'b111, 3'b100, 1, 2, 1};
    tbl[4]  = '{0, 0, 1, 3'b111, 3'b001, 1, 0, 1};
    tbl[5]  = '{0, 0, 1, 3'b111, 3'b010, 1, 1, 1};
    tbl[6]  = '{0, 0, 1, 3'b111, 3'b100, 1, 2, 1};
    tbl[7]  = '{1, 0, 1, 3'b110, 3'b000, 0, 0, 1};  // sparse mem/term
    tbl[8]  = '{0, 0, 1, 3'b110, 3'b010, 1, 1, 1};
    tbl[9]  = '{0, 0, 1, 3'b110, 3'b100, 1, 2, 1};
    tbl[10] = '{0, 0, 1, 3'b110, 3'b010, 1, 1, 1};
    tbl[11] = '{0, 0, 1, 3'b110, 3'b100, 1, 2, 1};
    tbl[12] = '{0, 0, 1, 3'b111, 3'b001, 1, 0, 1};  // drive pointer to 2
    tbl[13] = '{0, 0, 1, 3'b111, 3'b010, 1, 1, 1};
    tbl[14] = '{0, 1, 1, 3'b111, 3'b000, 0, 0, 0};  // flush collides with handshake
    tbl[15] = '{0, 0, 1, 3'b111, 3'b000, 0, 0, 0};  // FLUSH cycle
    tbl[16] = '{0, 0, 1, 3'b111, 3'b001, 1, 0, 1};  // restart at alu
    tbl[17] = '{0, 0, 1, 3'b000, 3'b000, 0, 0, 0};  // drain to empty

    rst = 1; flush = 0; out_ready = 0;
    alu_op = dir_op(2'd0); mem_op = dir_op(2'd1); term_op = dir_op(2'd2);
    {term_op_valid, mem_op_valid, alu_op_valid} = 3'b000;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].r, tbl[i].f, tbl[i].rdy, tbl[i].v,
          tbl[i].erdy, tbl[i].eov, tbl[i].esrc, tbl[i].csrc);
    end

    // Backpressure: alu op held stable for 5 stalled cycles, then mem wins.
    cyc("bp_rst", 1, 0, 1, 3'b111, 3'b000, 0, 0, 1);
    cyc("bp_alu", 0, 0, 1, 3'b111, 3'b001, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("bp_hold%0d", i), 0, 0, 0, 3'b111, 3'b000, 1, 0, 1);
    end
    cyc("bp_release", 0, 0, 1, 3'b111, 3'b010, 1, 1, 1);

    // Mid-operation reset with rr_ptr at 2 and an op held.
    cyc("mr_rst0", 1, 0, 1, 3'b111, 3'b000, 0, 0, 1);
    cyc("mr_alu", 0, 0, 1, 3'b111, 3'b001, 1, 0, 1);
    cyc("mr_mem", 0, 0, 1, 3'b111, 3'b010, 1, 1, 1);
    cyc("mr_rst", 1, 0, 0, 3'b111, 3'b000, 0, 0, 1);
    chk("mr_rst.out_op", 64'(out_op), 64'd0);
    cyc("mr_after", 0, 0, 1, 3'b111, 3'b001, 1, 0, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r   = (i == 0) || ($urandom_range(0, 99) < 2);
      f   = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 70);
      rst = r; flush = f; out_ready = rdy;
      {term_op_valid, mem_op_valid, alu_op_valid} = 3'($urandom_range(0, 7));
      alu_op = OP_W'($urandom); mem_op = OP_W'($urandom); term_op = OP_W'($urandom);
      @(negedge clk);
      model_cycle(erdy);
      chk($sformatf("rnd%0d.ready", i),
          64'({term_op_ready, mem_op_ready, alu_op_ready}), 64'(erdy));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d.out_valid", i), 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk($sformatf("rnd%0d.out_src", i), 64'(out_src), 64'(m_src));
        chk($sformatf("rnd%0d.out_op", i), 64'(out_op), 64'(m_op));
      end
`ifdef ISSUE_ARB_PERF_EN
      chk($sformatf("rnd%0d.perf_alu", i),   64'(perf_alu_cnt),   64'(m_cnt[0]));
      chk($sformatf("rnd%0d.perf_mem", i),   64'(perf_mem_cnt),   64'(m_cnt[1]));
      chk($sformatf("rnd%0d.perf_term", i),  64'(perf_term_cnt),  64'(m_cnt[2]));
      chk($sformatf("rnd%0d.perf_stall", i), 64'(perf_stall_cnt), 64'(m_cnt[3]));
`endif
      if (i % 500 == 0) begin
        $display("txn rnd%0d: rst=%b flush=%b rdy=%b out_valid=%b", i, r, f, rdy, out_valid);
      end
    end

`ifdef ISSUE_ARB_PERF_EN
    // Saturation: 70000 alu-only grants, then a flush must not clear counters.
    cyc("pf_rst", 1, 0, 1, 3'b000, 3'b000, 0, 0, 1);
    alu_op = dir_op(2'd0);
    rst = 0; flush = 0; out_ready = 1;
    {term_op_valid, mem_op_valid, alu_op_valid} = 3'b001;
    repeat (70000) @(posedge clk);
    #1;
    chk("pf_sat.alu", 64'(perf_alu_cnt), 64'hFFFF);
    chk("pf_sat.mem", 64'(perf_mem_cnt), 64'd0);
    cyc("pf_flush", 0, 1, 1, 3'b000, 3'b000, 0, 0, 0);
    cyc("pf_settle", 0, 0, 1, 3'b000, 3'b000, 0, 0, 0);
    chk("pf_flush.alu", 64'(perf_alu_cnt), 64'hFFFF);
    chk("pf_flush.term", 64'(perf_term_cnt), 64'd0);
    chk("pf_flush.stall", 64'(perf_stall_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_arbiter.md
# issue_arbiter

Shares the single execute dispatch port between the frontend's three issue buffers (arithmetic, memory, terminal). Each cycle it picks at most one ready op round-robin and loads it into a one-entry output register with its source tag. It sits between the frontend's alu/mem/term op outputs and the register-read/execute stage. A one-cycle-plus-settle flush sequence empties it after redirects.

## Interface
- OP_W, default `RENAMED_OP_SZ: width of one renamed op.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_op, mem_op, term_op  in  OP_W each  candidate ops from the issue buffers.
- alu_op_valid, mem_op_valid, term_op_valid  in  1 each  candidate present.
- alu_op_ready, mem_op_ready, term_op_ready  out  1 each  grant; the op is consumed when valid and ready are both high.
- flush  in  1  single-cycle pulse; discards the held op and restarts arbitration.
- out_op  out  OP_W  registered granted op.
- out_src  out  2  source tag: 0 alu, 1 mem, 2 term.
- out_valid  out  1  out_op holds an op.
- out_ready  in  1  execute stage accepts out_op.
- perf_alu_cnt, perf_mem_cnt, perf_term_cnt, perf_stall_cnt  out  16 each  only present with ISSUE_ARB_PERF_EN.

## Operation
- FSM states:
  - RUN (reset state).
  - FLUSH.
- Transitions:
  - RUN to FLUSH when flush=1.
  - FLUSH to RUN unconditionally after one cycle.
  - flush=1 while in FLUSH stays in FLUSH.
- Load enable: `load = state==RUN & ~flush & (~out_valid | out_ready)`.
- Arbitration:
  - rr_ptr is 2 bits and only takes values 0..2.
  - Search order is rr_ptr, (rr_ptr+1) mod 3, (rr_ptr+2) mod 3.
  - The first valid source in that order wins.
- Readies:
  - The ready of the winning source = load.
  - All other readies are 0.
  - No ready is asserted for a source whose valid is low.
  - All readies are 0 while rst is high.
- On a grant to source i:
  - out_op <= that op.
  - out_src <= i.
  - out_valid <= 1.
  - rr_ptr <= (i+1) mod 3.
- Load enable with no valid source: out_valid <= 0 if out_ready; rr_ptr is unchanged.
- Output hold: with out_valid=1 and out_ready=0, out_op and out_src are held stable and no grant is made.
- flush=1:
  - out_valid <= 0 and rr_ptr <= 0.
  - No grant in the flush cycle or in the FLUSH cycle.
  - flush overrides a same-cycle out_ready handshake; that op is dropped, not reissued.
- Reset values: out_valid 0, out_op 0, out_src 0, rr_ptr 0, state RUN, perf counters 0.

## Timing
- Latency: a grant at edge N makes the op visible on out_* after edge N.
- Throughput: one op per cycle while out_ready=1 (no bubble).
- Readies are combinational from the valids, out_valid, out_ready, state and flush. The valids must not depend on the readies.
- Flush recovery: the first grant after flush pulse at cycle N happens in cycle N+2.
- rst has priority over flush.

## Configuration
- ISSUE_ARB_PERF_EN defined:
  - Four 16-bit counters, each saturating at 16'hFFFF.
  - perf_*_cnt (alu/mem/term) increments on each grant to that source.
  - perf_stall_cnt increments on each cycle with any valid high and no grant, excluding rst cycles.
  - Counters are cleared by rst only, not by flush.
- Without the macro: the counter ports and logic are absent. Arbitration is identical.

## Structure
- Shared package holds:
  - ISSUE_SRC_ALU=2'd0, ISSUE_SRC_MEM=2'd1, ISSUE_SRC_TERM=2'd2.
  - The FSM state encoding.
- `RENAMED_OP_SZ stays in the global defines.
- One sub-module, rr_pick3: combinational 3-way round-robin picker with inputs req[2:0] and ptr[1:0], and outputs gnt[2:0] (one-hot) and gnt_idx[1:0].

## Test plan
- Rotation:
  - Stimulus: reset, then all three valid continuously with out_ready=1.
  - Response: out_src sequence 0,1,2,0,1,2. Each ready pulses once per 3 cycles. out_valid is continuous from cycle 1.
- Sparse sources:
  - Stimulus: only mem and term valid, rr_ptr=0.
  - Response: mem first, then term, then mem. alu_op_ready never asserts.
- Backpressure:
  - Stimulus: grant alu op 0xAB, then hold out_ready=0 for 5 cycles with all valids high.
  - Response: out_op=0xAB and out_src=0 stable, all readies 0. On release, next grant is mem.
- Flush collision:
  - Stimulus: out_valid=1, out_ready=1 and flush=1 in the same cycle.
  - Response: out_valid=0 the next cycle, no readies for 2 cycles. First grant goes to alu (rr_ptr=0) even if rr_ptr was 2 before.
- Mid-operation reset:
  - Stimulus: assert rst while out_valid=1 and rr_ptr=2.
  - Response: next cycle out_valid=0, out_src=0, rr_ptr=0, readies 0 during rst.
- Perf counters (ISSUE_ARB_PERF_EN):
  - Stimulus: 70000 alu-only grants.
  - Response: perf_alu_cnt=16'hFFFF, perf_mem_cnt=0. A flush does not clear the counters.
